// File: rtl/mixdown_i2s_tx_if.sv
// Mixer-to-I2S sample handshake: unsigned mixed-down word with valid/ready.
interface mixdown_i2s_tx_if #(
    parameter int IN_W = 11
);
    logic [IN_W-1:0] mix_in;
    logic            mix_valid;
    logic            mix_ready;

    modport master (output mix_in, output mix_valid, input mix_ready);
    modport slave  (input mix_in, input mix_valid, output mix_ready);
endinterface

// File: rtl/mixdown_i2s_tx.sv
// Mono mixer output to I2S DAC: DC-offset removal, gain, one-entry buffer, BCLK/LRCK generation.
// Define MIXDOWN_SAT_EN to clamp the scaled word instead of letting it wrap.
module mixdown_i2s_tx #(
    parameter int IN_W       = 11,
    parameter int OUT_W      = 16,
    parameter int GAIN_SHIFT = 5,
    parameter int BCLK_HALF  = 16
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    mixdown_i2s_tx_if.slave mix,
    output logic            AUD_BCLK,
    output logic            AUD_DACLRCK,
    output logic            AUD_DACDAT,
    output logic            frame_start,
    output logic            underrun
);
    localparam int SLOTS  = 2 * OUT_W;
    localparam int HC_W   = $clog2(BCLK_HALF);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int WIDE_W = (IN_W + 1 + GAIN_SHIFT > OUT_W + 1) ? IN_W + 1 + GAIN_SHIFT : OUT_W + 1;
    localparam logic [HC_W-1:0]   HC_LAST   = HC_W'(BCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_R    = SLOT_W'(OUT_W);

`ifdef MIXDOWN_SAT_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] fit_word(input logic signed [WIDE_W-1:0] x);
        if (x > SAT_MAX)
            fit_word = OUT_W'(SAT_MAX);
        else if (x < SAT_MIN)
            fit_word = OUT_W'(SAT_MIN);
        else
            fit_word = OUT_W'(x);
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] fit_word(input logic signed [WIDE_W-1:0] x);
        fit_word = OUT_W'(x);
    endfunction
`endif

    function automatic logic signed [OUT_W-1:0] to_word(input logic [IN_W-1:0] sample);
        logic signed [IN_W:0]     centred;
        logic signed [WIDE_W-1:0] scaled;
        centred = $signed({1'b0, sample}) - $signed({2'b01, {(IN_W-1){1'b0}}});
        scaled  = WIDE_W'(centred) <<< GAIN_SHIFT;
        to_word = fit_word(scaled);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    // holding-buffer stage
    logic signed [OUT_W-1:0] buf_word_p0;
    logic                    vld_p0;

    // serializer stage
    logic signed [OUT_W-1:0] shift_p1;
    logic signed [OUT_W-1:0] last_word_p1;
    logic [HC_W-1:0]         half_cnt_q;
    logic [SLOT_W-1:0]       slot_q;
    logic [SLOT_W-1:0]       slot_nx;
    logic                    bclk_q;
    logic                    lrck_q;
    logic                    dat_q;

    logic xfer;
    logic tick;
    logic fall;
    logic fs;

    assign mix.mix_ready = ~vld_p0;
    assign xfer          = mix.mix_valid & ~vld_p0;
    assign AUD_BCLK      = bclk_q;
    assign AUD_DACLRCK   = lrck_q;
    assign AUD_DACDAT    = dat_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        fall    = 1'b0;
        fs      = 1'b0;
        case (state_q)
            IDLE: if (xfer) state_d = RUN;
            RUN: begin
                tick = (half_cnt_q == HC_LAST);
                fall = tick & bclk_q;
                fs   = (half_cnt_q == '0) & ~bclk_q & (slot_q == '0);
            end
            default: state_d = IDLE;
        endcase
        slot_nx     = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        frame_start = fs;
        underrun    = fs & ~vld_p0;
    end

    // Each BCLK fall emits the MSB of a rotating copy of the word, so the slot
    // after every LRCK change naturally carries the previous channel's LSB.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vld_p0       <= 1'b0;
            last_word_p1 <= '0;
            half_cnt_q   <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= '0;
            lrck_q       <= 1'b0;
            dat_q        <= 1'b0;
        end else begin
            if (xfer)
                vld_p0 <= 1'b1;
            else if (fs)
                vld_p0 <= 1'b0;
            if (fs && vld_p0)
                last_word_p1 <= buf_word_p0;
            if (state_q == RUN) begin
                half_cnt_q <= tick ? '0 : half_cnt_q + 1'b1;
                if (tick)
                    bclk_q <= ~bclk_q;
                if (fall) begin
                    slot_q <= slot_nx;
                    lrck_q <= (slot_nx >= SLOT_R);
                    dat_q  <= shift_p1[OUT_W-1];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (xfer)
            buf_word_p0 <= to_word(mix.mix_in);
        if (fs)
            shift_p1 <= vld_p0 ? buf_word_p0 : last_word_p1;
        else if (fall)
            shift_p1 <= {shift_p1[OUT_W-2:0], shift_p1[OUT_W-1]};
    end
endmodule

// File: tb/tb_mixdown_i2s_tx.sv
// Scoreboard bench for mixdown_i2s_tx: directed samples, I2S decoder monitor, gain-6 side instance.
module tb_mixdown_i2s_tx;
    localparam int IN_W  = 11;
    localparam int OUT_W = 16;
`ifdef MIXDOWN_SAT_EN
    localparam int EXP_G6 = 32'h7FFF;
`else
    localparam int EXP_G6 = 32'hFFC0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mixdown_i2s_tx_if #(.IN_W(IN_W)) bus();
    mixdown_i2s_tx_if #(.IN_W(IN_W)) bus2();

    logic bclk, lrck, dat, fs, ur;
    logic bclk2, lrck2, dat2, fs2, ur2;

    mixdown_i2s_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SHIFT(5), .BCLK_HALF(16)) dut (
        .CLOCK_50(clk), .resetn(resetn), .mix(bus.slave),
        .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
        .frame_start(fs), .underrun(ur));

    mixdown_i2s_tx #(.IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SHIFT(6), .BCLK_HALF(2)) dut_g6 (
        .CLOCK_50(clk), .resetn(resetn), .mix(bus2.slave),
        .AUD_BCLK(bclk2), .AUD_DACLRCK(lrck2), .AUD_DACDAT(dat2),
        .frame_start(fs2), .underrun(ur2));

    int errors = 0;
    int checks = 0;

    logic [15:0] word_q[$];
    bit          fs_q[$];
    int          words_done = 0;
    int          ur_count   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: decodes the I2S stream and checks frame starts against the scoreboard.
    int          cyc = 0;
    int          last_fs = 0;
    bit          first_fs = 1'b1;
    bit          have = 1'b0;
    logic        prev_bclk = 1'b0;
    logic        prev_lrck = 1'b0;
    logic [14:0] acc = '0;
    int          nbits = 0;
    logic [15:0] word;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            first_fs  = 1'b1;
            have      = 1'b0;
            prev_bclk = 1'b0;
            prev_lrck = 1'b0;
            acc       = '0;
            nbits     = 0;
            word_q.delete();
            fs_q.delete();
        end else begin
            if (ur) ur_count++;
            if (fs) begin
                if (fs_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fs_unexpected: frame start at cycle %0d with no expectation", cyc);
                end else begin
                    check("underrun_at_fs", int'(ur), int'(fs_q.pop_front()));
                end
                if (first_fs)
                    check("restart_lrck_bclk", int'({lrck, bclk}), 0);
                else
                    check("frame_period", cyc - last_fs, 1024);
                first_fs = 1'b0;
                last_fs  = cyc;
            end
            if (bclk && !prev_bclk) begin
                if (!have) begin
                    have = 1'b1;
                end else if (lrck != prev_lrck) begin
                    word = {acc, dat};
                    check("slot_count", nbits, 15);
                    if (word_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word_unexpected: got 0x%0h with empty scoreboard", word);
                    end else if (!prev_lrck) begin
                        check("left_word", int'(word), int'(word_q[0]));
                    end else begin
                        check("right_word", int'(word), int'(word_q.pop_front()));
                        words_done++;
                    end
                    acc   = '0;
                    nbits = 0;
                end else begin
                    acc = {acc[13:0], dat};
                    nbits++;
                end
                prev_lrck = lrck;
            end
            prev_bclk = bclk;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_bclk"},  int'(bclk), 0);
        check({tag, "_lrck"},  int'(lrck), 0);
        check({tag, "_dat"},   int'(dat),  0);
        check({tag, "_fs"},    int'(fs),   0);
        check({tag, "_ur"},    int'(ur),   0);
        check({tag, "_ready"}, int'(bus.mix_ready), 1);
    endtask

    task automatic mid_reset(input string tag);
        repeat (200) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset({tag, "_midreset"});
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_phase(input string tag, input int n, input int k,
                             input logic [10:0] s0, input logic [10:0] s1, input logic [10:0] s2,
                             input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        logic [10:0] s[3];
        logic [15:0] w[3];
        bit          got;
        int          ur_base;
        int          wd_base;
        int          t;
        s       = '{s0, s1, s2};
        w       = '{w0, w1, w2};
        ur_base = ur_count;
        wd_base = words_done;
        for (int i = 0; i <= k; i++) fs_q.push_back(i >= n);
        for (int i = 0; i < k; i++) word_q.push_back(w[(i < n) ? i : n - 1]);
        for (int i = 0; i < n; i++) begin
            bus.mix_in    = s[i];
            bus.mix_valid = 1'b1;
            got = 1'b0;
            for (int j = 0; j < 4000 && !got; j++) begin
                if (bus.mix_ready) got = 1'b1;
                @(negedge clk);
            end
            check({tag, "_accept"}, int'(got), 1);
            if (got) check({tag, "_ready_drop"}, int'(bus.mix_ready), 0);
        end
        bus.mix_valid = 1'b0;
        t = 0;
        while (words_done - wd_base < k && t < (k + 2) * 1100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_frames"}, words_done - wd_base, k);
        check({tag, "_words_left"}, word_q.size(), 0);
        check({tag, "_fs_left"}, fs_q.size(), 0);
        check({tag, "_underruns"}, ur_count - ur_base, k + 1 - n);
        mid_reset(tag);
    endtask

    initial begin
        bit          got;
        int          rises;
        logic        prevb;
        logic [15:0] lw;
        logic [15:0] rw;
        bus.mix_valid  = 1'b0;
        bus.mix_in     = '0;
        bus2.mix_valid = 1'b0;
        bus2.mix_in    = '0;
        #2 resetn = 1'b0;
        #1 check_reset("reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_phase("silence",   1, 3, 11'd1024, 11'd0,   11'd0,    16'h0000, 16'h0000, 16'h0000);
        run_phase("extremes",  2, 3, 11'd2047, 11'd0,   11'd0,    16'h7FE0, 16'h8000, 16'h0000);
        run_phase("backpress", 3, 4, 11'd1536, 11'd512, 11'd1025, 16'h4000, 16'hC000, 16'h0020);
        run_phase("repeat",    1, 3, 11'd1023, 11'd0,   11'd0,    16'hFFE0, 16'h0000, 16'h0000);

        bus2.mix_in    = 11'd2047;
        bus2.mix_valid = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 50 && !got; j++) begin
            if (bus2.mix_ready) got = 1'b1;
            @(negedge clk);
        end
        bus2.mix_valid = 1'b0;
        check("g6_accept", int'(got), 1);
        got = 1'b0;
        for (int j = 0; j < 50 && !got; j++) begin
            if (fs2) got = 1'b1;
            else @(negedge clk);
        end
        check("g6_frame_start", int'(got), 1);
        rises = 0;
        prevb = 1'b0;
        lw    = '0;
        rw    = '0;
        for (int j = 0; j < 2000 && rises < 33; j++) begin
            if (bclk2 && !prevb) begin
                if (rises >= 1 && rises <= 16) lw = {lw[14:0], dat2};
                else if (rises >= 17) rw = {rw[14:0], dat2};
                rises++;
            end
            prevb = bclk2;
            @(negedge clk);
        end
        check("g6_slots", rises, 33);
        check("g6_left_word", int'(lw), EXP_G6);
        check("g6_right_word", int'(rw), EXP_G6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
